// File: rtl/rs_enc_ctrl.sv
// rtl/rs_enc_ctrl.sv - frame sequencer for a systematic RS(N,K) GF(2^8) encoder
// Drives the shared feedback symbol into the generator stages and muxes message/parity onto the output.
module rs_enc_ctrl #(
    parameter int K    = 239,
    parameter int NPAR = 16,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic [W-1:0] par_fb,
    output logic [W-1:0] mr,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    output logic         out_is_par,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         err_abort
);

    localparam int MAXC = (K > NPAR) ? K : NPAR;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] CNT_MSG_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_PAR_LAST = CW'(NPAR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MSG   = 2'd1,
        PAR   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic          out_is_par_q, out_is_par_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          err_abort_q, err_abort_d;

    // take: this cycle's in_data is a legal message symbol and enters the chain
    logic take;
    logic sym_ok;

    assign sym_ok = in_valid && !in_sop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_is_par_q <= 1'b0;
            out_data_q   <= '0;
            err_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_is_par_q <= out_is_par_d;
            out_data_q   <= out_data_d;
            err_abort_q  <= err_abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) begin
                    state_d = MSG;
                    cnt_d   = CW'(1);
                end
            end
            MSG: begin
                if (sym_ok) begin
                    if (cnt_q == CNT_MSG_LAST) begin
                        state_d = PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // gap or stray sop inside a frame: chain must be drained
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            PAR, FLUSH: begin
                if (cnt_q == CNT_PAR_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready     = rst && ((state_q == IDLE) || (state_q == MSG));
        take         = rst && (((state_q == IDLE) && in_valid && in_sop) ||
                               ((state_q == MSG) && sym_ok));
        mr           = take ? (in_data ^ par_fb) : '0;
        out_valid_d  = take || (state_q == PAR);
        out_sop_d    = take && (state_q == IDLE);
        out_eop_d    = (state_q == PAR) && (cnt_q == CNT_PAR_LAST);
        out_is_par_d = (state_q == PAR);
        out_data_d   = (state_q == PAR) ? par_fb : (take ? in_data : '0);
        err_abort_d  = ((state_q == IDLE) && in_valid && !in_sop) ||
                       ((state_q == MSG) && !sym_ok);
    end

    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_is_par = out_is_par_q;
    assign out_data   = out_data_q;
    assign err_abort  = err_abort_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// tb/tb_rs_enc_ctrl.sv - self-checking bench for rs_enc_ctrl
module tb_rs_enc_ctrl;

    localparam int K    = 239;
    localparam int NPAR = 16;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_sop;
    logic [7:0] in_data, par_fb;
    logic       in_ready, out_valid, out_sop, out_eop, out_is_par, busy, err_abort;
    logic [7:0] mr, out_data;

    always #5 clk = ~clk;

    rs_enc_ctrl #(.K(K), .NPAR(NPAR), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .in_ready(in_ready), .par_fb(par_fb), .mr(mr),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_is_par(out_is_par), .out_data(out_data), .busy(busy),
        .err_abort(err_abort)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pos 0 = idle, 1..K-1 = next message index, K..K+NPAR-1 = parity index + K.
    int         m_pos = 0;
    int         m_flush = 0;
    logic       x_rdy;
    logic [7:0] x_mr;
    logic       e_valid, e_sop, e_eop, e_par, e_err;
    logic [7:0] e_data;

    task automatic model_step(input logic r, v, s, input logic [7:0] d, f);
        x_rdy = 1'b0; x_mr = 8'h00;
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_par = 1'b0; e_err = 1'b0; e_data = 8'h00;
        if (!r) begin
            m_pos = 0; m_flush = 0;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_pos >= K) begin
            e_valid = 1'b1; e_par = 1'b1; e_data = f;
            e_eop = (m_pos - K == NPAR - 1);
            m_pos = e_eop ? 0 : m_pos + 1;
        end else if (m_pos == 0) begin
            x_rdy = 1'b1;
            if (v && s) begin
                x_mr = d ^ f; e_valid = 1'b1; e_sop = 1'b1; e_data = d; m_pos = 1;
            end else if (v) begin
                e_err = 1'b1;
            end
        end else begin
            x_rdy = 1'b1;
            if (v && !s) begin
                x_mr = d ^ f; e_valid = 1'b1; e_data = d; m_pos++;
            end else begin
                e_err = 1'b1; m_flush = NPAR; m_pos = 0;
            end
        end
    endtask

    int obs_valid, obs_sop, obs_eop, obs_par, obs_err, obs_notready, run, max_run;

    task automatic clr_obs();
        obs_valid = 0; obs_sop = 0; obs_eop = 0; obs_par = 0; obs_err = 0;
        obs_notready = 0; run = 0; max_run = 0;
    endtask

    task automatic cycle(input logic r, v, s, input logic [7:0] d, f);
        logic x_busy;
        @(negedge clk);
        rst = r; in_valid = v; in_sop = s; in_data = d; par_fb = f;
        #1;
        x_busy = (m_pos != 0) || (m_flush != 0);
        model_step(r, v, s, d, f);
        chk("in_ready", in_ready, x_rdy);
        chk("mr", mr, x_mr);
        chk("busy", busy, x_busy);
        if (!in_ready) obs_notready++;
        @(posedge clk); #1;
        chk("out_valid", out_valid, e_valid);
        chk("out_sop", out_sop, e_sop);
        chk("out_eop", out_eop, e_eop);
        chk("out_is_par", out_is_par, e_par);
        chk("out_data", out_data, e_data);
        chk("err_abort", err_abort, e_err);
        if (out_valid) begin obs_valid++; run++; if (run > max_run) max_run = run; end
        else run = 0;
        if (out_sop) obs_sop++;
        if (out_eop) obs_eop++;
        if (out_is_par) obs_par++;
        if (err_abort) obs_err++;
    endtask

    // err_at < 0: full frame plus parity phase; otherwise in_valid drops at that index.
    task automatic frame(input bit seq_data, input bit rnd_fb, input logic [7:0] fb, input int err_at);
        logic [7:0] d, f;
        for (int i = 0; i < K; i++) begin
            d = seq_data ? 8'(i + 1) : 8'($urandom);
            f = rnd_fb ? 8'($urandom) : fb;
            if (i == err_at) begin
                cycle(1'b1, 1'b0, 1'b0, d, f);
                return;
            end
            cycle(1'b1, 1'b1, (i == 0), d, f);
        end
        for (int j = 0; j < NPAR; j++)
            cycle(1'b1, 1'b0, 1'b0, 8'($urandom), rnd_fb ? 8'($urandom) : fb);
    endtask

    typedef struct {
        logic       r, v, s;
        logic [7:0] d, f;
        logic       x_ready;
        logic [7:0] x_mr;
        logic       x_err;
    } vec_t;

    vec_t tv[6];

    initial begin
        tv[0] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 1'b1, 8'h00, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b1, 8'h00, 1'b1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h0F, 1'b1, 8'h00, 1'b0};
        tv[4] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00; par_fb = 8'h00;
        clr_obs();
        repeat (2) @(posedge clk);

        // reset held for 5 clocks with junk on the inputs
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0; #1;
        chk("post_rst_ready", in_ready, 1'b1);

        // idle-state vectors, none of which may leave IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = tv[i].r; in_valid = tv[i].v; in_sop = tv[i].s & ~tv[i].r ? 1'b1 : tv[i].s;
            if (tv[i].r && tv[i].v && tv[i].s) in_valid = 1'b0;
            in_data = tv[i].d; par_fb = tv[i].f;
            #1;
            chk("tv_ready", in_ready, tv[i].x_ready);
            chk("tv_mr", mr, tv[i].x_mr);
            @(posedge clk); #1;
            chk("tv_err", err_abort, tv[i].x_err);
            chk("tv_out_valid", out_valid, 1'b0);
            chk("tv_busy", busy, 1'b0);
        end
        m_pos = 0; m_flush = 0;

        // full frame, ramp data, constant feedback
        clr_obs();
        frame(1'b1, 1'b0, 8'hA5, -1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'hA5);
        chk("f2_valid", obs_valid, K + NPAR);
        chk("f2_sop", obs_sop, 1);
        chk("f2_eop", obs_eop, 1);
        chk("f2_par", obs_par, NPAR);

        // in_valid drops at message symbol 100
        clr_obs();
        frame(1'b0, 1'b1, 8'h00, 100);
        for (int i = 0; i < NPAR + 1; i++)
            cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        chk("abort_err", obs_err, 1);
        chk("abort_notready", obs_notready, NPAR);
        chk("abort_eop", obs_eop, 0);

        // two frames back to back
        clr_obs();
        frame(1'b0, 1'b1, 8'h00, -1);
        frame(1'b0, 1'b1, 8'h00, -1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("b2b_run", max_run, 2 * (K + NPAR));
        chk("b2b_sop", obs_sop, 2);
        chk("b2b_eop", obs_eop, 2);

        // reset while parity index 7 is being emitted
        frame(1'b0, 1'b1, 8'h00, 0);
        for (int i = 0; i < NPAR; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < K; i++) cycle(1'b1, 1'b1, (i == 0), 8'($urandom), 8'($urandom));
        for (int j = 0; j < 7; j++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h77);
        chk("rst_par_busy", busy, 1'b0);
        chk("rst_par_valid", out_valid, 1'b0);
        clr_obs();
        frame(1'b0, 1'b1, 8'h00, -1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("clean_valid", obs_valid, K + NPAR);
        chk("clean_eop", obs_eop, 1);

        // randomized traffic: gaps, stray sops, aborts and occasional resets
        for (int n = 0; n < 20; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                frame(1'b0, 1'b1, 8'h00, $urandom_range(1, K - 1));
                for (int i = 0; i < NPAR; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            end else if (kind == 1) begin
                for (int i = 0; i < 40; i++)
                    cycle(($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                          8'($urandom), 8'($urandom));
            end else begin
                frame(1'b0, 1'b1, 8'h00, -1);
            end
            for (int i = 0; i < $urandom_range(0, 2); i++)
                cycle(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        // leave the random phase in a known state
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        frame(1'b0, 1'b1, 8'h00, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
